// File: rtl/sal_axi_addr_arbiter_pkg.sv
// rtl/sal_axi_addr_arbiter_pkg.sv - shared types for the AW/AR address arbiter
// Holds the arbiter state enum, the merged command record and the default widths.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package sal_arb_pkg;

    localparam int ARB_LEN_W = 4;

    typedef enum logic {
        NORMAL   = 1'b0,
        WR_FORCE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                       wr;
        logic [`AXI_ID_WIDTH-1:0]   id;
        logic [`AXI_ADDR_WIDTH-1:0] addr;
        logic [ARB_LEN_W-1:0]       len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
    } axi_cmd_t;

endpackage

// File: rtl/sal_axi_addr_arbiter_if.sv
// rtl/sal_axi_addr_arbiter_if.sv - AW/AR address channels plus merged command stream
// slave modport: arbiter side (AW/AR in, cmd out); master modport: the surrounding logic.
interface sal_axi_addr_arbiter_if #(
    parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
    parameter int ID_WIDTH   = `AXI_ID_WIDTH,
    parameter int ADDR_LEN   = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [ADDR_LEN-1:0]   awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [ADDR_LEN-1:0]   arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_LEN-1:0]   cmd_len;
    logic [2:0]            cmd_size;
    logic [1:0]            cmd_burst;

    logic [ADDR_LEN:0]     wdata_beats;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        input  cmd_ready, wdata_beats,
        output awready, arready,
        output cmd_valid, cmd_wr, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        output cmd_ready, wdata_beats,
        input  awready, arready,
        input  cmd_valid, cmd_wr, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst
    );
endinterface

// File: rtl/sal_axi_addr_arbiter_cmd_slice.sv
// rtl/sal_axi_addr_arbiter_cmd_slice.sv - one-entry valid/ready register stage for axi_cmd_t
// Ports: clk, rst_n; in_valid/in_data (no ready: caller only offers when load=1);
// load = stage can accept this cycle; out_valid/out_ready/out_data downstream.
module sal_cmd_slice
    import sal_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    input  axi_cmd_t in_data,
    output logic     load,
    output logic     out_valid,
    input  logic     out_ready,
    output axi_cmd_t out_data
);

    // Empty or draining this cycle: accept a new entry, giving full throughput.
    assign load = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/sal_axi_addr_arbiter.sv
// rtl/sal_axi_addr_arbiter.sv - read-priority AW/AR merge with write-starvation limit
// Ports: clk, rst_n (sync, active-low); bus (slave modport): AW/AR address channels in,
// registered merged command out, wdata_beats for the optional gate.
// Optional macro SAL_ARB_WDATA_GATE_EN: AW is eligible only when wdata_beats >= awlen+1.
module sal_axi_addr_arbiter
    import sal_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
    parameter int ID_WIDTH        = `AXI_ID_WIDTH,
    parameter int ADDR_LEN        = ARB_LEN_W,
    parameter int WR_STARVE_LIMIT = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    sal_axi_addr_arbiter_if.slave bus
);

    localparam int CNT_W = (WR_STARVE_LIMIT > 0) ? $clog2(WR_STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WR_STARVE_LIMIT);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             load;
    logic             aw_elig;
    logic             force_aw;
    logic             grant_aw;
    logic             grant_ar;
    axi_cmd_t         cmd_in;
    axi_cmd_t         cmd_out;

    logic [ID_WIDTH-1:0]   gnt_id;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [ADDR_LEN-1:0]   gnt_len;
    logic [2:0]            gnt_size;
    logic [1:0]            gnt_burst;

`ifdef SAL_ARB_WDATA_GATE_EN
    assign aw_elig = bus.awvalid &&
                     (bus.wdata_beats >= ({1'b0, bus.awlen} + {{ADDR_LEN{1'b0}}, 1'b1}));
`else
    logic unused_wdata_beats;
    assign unused_wdata_beats = ^bus.wdata_beats;
    assign aw_elig = bus.awvalid;
`endif

    // A zero limit means an eligible write always wins, even before the FSM reacts.
    assign force_aw = (state == WR_FORCE) || ((WR_STARVE_LIMIT == 0) && aw_elig);

    assign grant_aw = rst_n && load && aw_elig && (force_aw || !bus.arvalid);
    assign grant_ar = rst_n && load && bus.arvalid && !force_aw;

    assign bus.awready = grant_aw;
    assign bus.arready = grant_ar;

    assign gnt_id    = grant_aw ? bus.awid    : bus.arid;
    assign gnt_addr  = grant_aw ? bus.awaddr  : bus.araddr;
    assign gnt_len   = grant_aw ? bus.awlen   : bus.arlen;
    assign gnt_size  = grant_aw ? bus.awsize  : bus.arsize;
    assign gnt_burst = grant_aw ? bus.awburst : bus.arburst;
    assign cmd_in    = '{wr: grant_aw, id: gnt_id, addr: gnt_addr, len: gnt_len,
                         size: gnt_size, burst: gnt_burst};

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        if (grant_aw) begin
            starve_nxt = '0;
        end else if (grant_ar && aw_elig && (starve_cnt != LIMIT_C)) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
        case (state)
            NORMAL: begin
                if (aw_elig && (starve_nxt == LIMIT_C)) begin
                    state_nxt = WR_FORCE;
                end
            end
            WR_FORCE: begin
                // Raw awvalid here: a gated-off AW keeps the force until it is granted.
                if (grant_aw || !bus.awvalid) begin
                    state_nxt = NORMAL;
                end
            end
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    sal_cmd_slice u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (grant_aw || grant_ar),
        .in_data   (cmd_in),
        .load      (load),
        .out_valid (bus.cmd_valid),
        .out_ready (bus.cmd_ready),
        .out_data  (cmd_out)
    );

    assign bus.cmd_wr    = cmd_out.wr;
    assign bus.cmd_id    = cmd_out.id;
    assign bus.cmd_addr  = cmd_out.addr;
    assign bus.cmd_len   = cmd_out.len;
    assign bus.cmd_size  = cmd_out.size;
    assign bus.cmd_burst = cmd_out.burst;

endmodule

// File: tb/tb_sal_axi_addr_arbiter.sv
// tb/tb_sal_axi_addr_arbiter.sv - bench for sal_axi_addr_arbiter (limits 4 and 0 side by side)
module tb_sal_axi_addr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, arvalid, cmd_ready;
    logic [3:0]  awid, arid, awlen, arlen;
    logic [31:0] awaddr, araddr;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic [4:0]  wdata_beats;

    always #5 clk = ~clk;

    sal_axi_addr_arbiter_if #(.ADDR_WIDTH(32), .ID_WIDTH(4), .ADDR_LEN(4)) bus_if [2] ();

    logic        o_awready [2];
    logic        o_arready [2];
    logic        o_valid   [2];
    logic        o_wr      [2];
    logic [3:0]  o_id      [2];
    logic [31:0] o_addr    [2];
    logic [3:0]  o_len     [2];
    logic [2:0]  o_size    [2];
    logic [1:0]  o_burst   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus_if[g].awvalid     = awvalid;
        assign bus_if[g].awid        = awid;
        assign bus_if[g].awaddr      = awaddr;
        assign bus_if[g].awlen       = awlen;
        assign bus_if[g].awsize      = awsize;
        assign bus_if[g].awburst     = awburst;
        assign bus_if[g].arvalid     = arvalid;
        assign bus_if[g].arid        = arid;
        assign bus_if[g].araddr      = araddr;
        assign bus_if[g].arlen       = arlen;
        assign bus_if[g].arsize      = arsize;
        assign bus_if[g].arburst     = arburst;
        assign bus_if[g].cmd_ready   = cmd_ready;
        assign bus_if[g].wdata_beats = wdata_beats;

        assign o_awready[g] = bus_if[g].awready;
        assign o_arready[g] = bus_if[g].arready;
        assign o_valid[g]   = bus_if[g].cmd_valid;
        assign o_wr[g]      = bus_if[g].cmd_wr;
        assign o_id[g]      = bus_if[g].cmd_id;
        assign o_addr[g]    = bus_if[g].cmd_addr;
        assign o_len[g]     = bus_if[g].cmd_len;
        assign o_size[g]    = bus_if[g].cmd_size;
        assign o_burst[g]   = bus_if[g].cmd_burst;

        sal_axi_addr_arbiter #(
            .ADDR_WIDTH      (32),
            .ID_WIDTH        (4),
            .ADDR_LEN        (4),
            .WR_STARVE_LIMIT ((g == 0) ? 4 : 0)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus_if[g])
        );
    end

    int total = 0;
    int bad   = 0;

    // Reference model: per instance, a "writes must win" flag, a count of reads
    // granted past a waiting write, and the command expected on the output register.
    int          lim [2] = '{4, 0};
    bit          m_force  [2];
    int          m_starve [2];
    bit          e_valid  [2];
    bit          e_wr     [2];
    logic [3:0]  e_id     [2];
    logic [31:0] e_addr   [2];
    logic [3:0]  e_len    [2];
    logic [2:0]  e_size   [2];
    logic [1:0]  e_burst  [2];
    bit          p_aw [2];
    bit          p_ar [2];
    bit          p_ld [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit aw_eligible();
`ifdef SAL_ARB_WDATA_GATE_EN
        return awvalid && (int'(wdata_beats) >= int'(awlen) + 1);
`else
        return awvalid;
`endif
    endfunction

    // Called at posedge+1 with inputs set; checks at the falling edge, then
    // advances the model across the next rising edge.
    task automatic step();
        bit ok, must_win;
        #4;
        ok = aw_eligible();
        for (int k = 0; k < 2; k++) begin
            p_ld[k]  = !e_valid[k] || cmd_ready;
            must_win = m_force[k] || (lim[k] == 0 && ok);
            p_aw[k]  = rst_n && p_ld[k] && ok && (must_win || !arvalid);
            p_ar[k]  = rst_n && p_ld[k] && arvalid && !must_win;
            chk($sformatf("L%0d_awready", lim[k]), o_awready[k], p_aw[k]);
            chk($sformatf("L%0d_arready", lim[k]), o_arready[k], p_ar[k]);
            chk($sformatf("L%0d_cmd_valid", lim[k]), o_valid[k], e_valid[k]);
            if (e_valid[k]) begin
                chk($sformatf("L%0d_cmd_wr", lim[k]), o_wr[k], e_wr[k]);
                chk($sformatf("L%0d_cmd_id", lim[k]), o_id[k], e_id[k]);
                chk($sformatf("L%0d_cmd_addr", lim[k]), o_addr[k], e_addr[k]);
                chk($sformatf("L%0d_cmd_len", lim[k]), o_len[k], e_len[k]);
                chk($sformatf("L%0d_cmd_size", lim[k]), o_size[k], e_size[k]);
                chk($sformatf("L%0d_cmd_burst", lim[k]), o_burst[k], e_burst[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                e_valid[k]  = 0;
                m_force[k]  = 0;
                m_starve[k] = 0;
            end else begin
                if (p_ld[k]) begin
                    e_valid[k] = p_aw[k] || p_ar[k];
                    if (p_aw[k]) begin
                        e_wr[k] = 1; e_id[k] = awid; e_addr[k] = awaddr;
                        e_len[k] = awlen; e_size[k] = awsize; e_burst[k] = awburst;
                    end else if (p_ar[k]) begin
                        e_wr[k] = 0; e_id[k] = arid; e_addr[k] = araddr;
                        e_len[k] = arlen; e_size[k] = arsize; e_burst[k] = arburst;
                    end
                end
                if (p_aw[k]) m_starve[k] = 0;
                else if (p_ar[k] && ok && m_starve[k] < lim[k]) m_starve[k]++;
                if (m_force[k]) m_force[k] = !(p_aw[k] || !awvalid);
                else            m_force[k] = ok && (m_starve[k] == lim[k]);
            end
        end
    endtask

    task automatic rand_fields();
        awid = 4'($urandom); awaddr = $urandom; awlen = 4'($urandom);
        awsize = 3'($urandom); awburst = 2'($urandom);
        arid = 4'($urandom); araddr = $urandom; arlen = 4'($urandom);
        arsize = 3'($urandom); arburst = 2'($urandom);
    endtask

    bit exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        rst_n = 0; awvalid = 1; arvalid = 1; cmd_ready = 1; wdata_beats = 5'd16;
        rand_fields();
        @(posedge clk);
        #1;
        repeat (3) step();

        // Both channels saturated: limit 4 gives R,R,R,R,W; limit 0 always writes.
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            step();
            chk($sformatf("starve_seq%0d", i), o_wr[0], exp_seq[i]);
            chk($sformatf("wr_always%0d", i), o_wr[1], 1'b1);
        end

        // Single read with fixed fields.
        awvalid = 0; arvalid = 1; araddr = 32'h0000_1000; arlen = 4'd3; arid = 4'd2;
        step();
        arvalid = 0;
        chk("rd_valid", o_valid[0], 1'b1);
        chk("rd_wr", o_wr[0], 1'b0);
        chk("rd_addr", o_addr[0], 32'h0000_1000);
        chk("rd_len", o_len[0], 32'd3);
        chk("rd_id", o_id[0], 32'd2);
        step();

        // Backpressure: stall for 5 cycles behind one captured read.
        arvalid = 1; araddr = 32'h0000_2000;
        step();
        cmd_ready = 0; awvalid = 1;
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            step();
            chk("bp_hold_addr", o_addr[0], 32'h0000_2000);
        end
        cmd_ready = 1;
        step();
        awvalid = 0; arvalid = 0;
        step();

`ifdef SAL_ARB_WDATA_GATE_EN
        awvalid = 1; awlen = 4'd7; wdata_beats = 5'd5;
        step();
        chk("gate_block", o_valid[0], 1'b0);
        wdata_beats = 5'd8;
        step();
        chk("gate_open_valid", o_valid[0], 1'b1);
        chk("gate_open_wr", o_wr[0], 1'b1);
`else
        awvalid = 1; awlen = 4'd7; wdata_beats = 5'd0;
        step();
        chk("nogate_valid", o_valid[0], 1'b1);
        chk("nogate_wr", o_wr[0], 1'b1);
`endif
        awvalid = 0;
        step();

        for (int i = 0; i < 400; i++) begin
            rand_fields();
            awvalid     = ($urandom_range(0, 9) < 7);
            arvalid     = ($urandom_range(0, 9) < 7);
            cmd_ready   = ($urandom_range(0, 3) != 0);
            wdata_beats = 5'($urandom_range(0, 16));
            step();
        end

        // Reset with a stalled command pending: it is dropped.
        cmd_ready = 0; arvalid = 1; awvalid = 1;
        step();
        step();
        rst_n = 0;
        step();
        chk("rst_drop0", o_valid[0], 1'b0);
        chk("rst_drop1", o_valid[1], 1'b0);
        rst_n = 1; cmd_ready = 1;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
